usb_auth_host_responder: RTL and testbench

Synthesizable, parametrised host-side responder for the USB Type-C authentication controller. It buffers host-to-controller authentication messages in a FIFO and answers controller output messages with a delayed acknowledge. It tracks the response-request handshake and keeps a per-channel queue of pending authentication requests (channel 0 = PD, channel 1 = DEBUG, extendable). It sits between the authentication controller and the PD/DEBUG driver logic, replacing the behavioural driver model in system-level simulation and in silicon.

---
 rtl/usb_auth_host_responder_if.sv | 43 ++++
 rtl/usb_auth_host_responder.sv | 195 +++++++++++++++++++
 tb/tb_usb_auth_host_responder.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/usb_auth_host_responder_if.sv
// Bus between the authentication controller / host driver logic and the
// host-side responder: message FIFO, acknowledge, response request, request queues.
interface usb_auth_host_responder_if #(
  parameter int MSG_LEN = 2048,
  parameter int NUM_CH  = 2
);
  logic                  load_valid;
  logic [MSG_LEN-1:0]    load_msg;
  logic                  load_ready;
  logic [MSG_LEN-1:0]    auth_msg_in;
  logic                  msg_avail;
  logic                  msg_pop;
  logic                  auth_msg_ready;
  logic [MSG_LEN-1:0]    auth_msg_out;
  logic [MSG_LEN-1:0]    last_msg_out;
  logic                  Ack_in_driver;
  logic                  resp_req_out;
  logic                  resp_rearm;
  logic                  resp_req_in;
  logic [NUM_CH-1:0]     req_push;
  logic [2*NUM_CH-1:0]   req_slot;
  logic [NUM_CH-1:0]     pending_auth_request_erase;
  logic [8*NUM_CH-1:0]   pending_auth_request;
  logic [3*NUM_CH-1:0]   pending_count;
  logic [NUM_CH-1:0]     ch_msg_ready;
  logic [NUM_CH-1:0]     req_overflow;

  // Driver side: host, controller and PD/DEBUG driver logic.
  modport master (
    output load_valid, load_msg, msg_pop, auth_msg_ready, auth_msg_out,
           resp_req_out, resp_rearm, req_push, req_slot, pending_auth_request_erase,
    input  load_ready, auth_msg_in, msg_avail, last_msg_out, Ack_in_driver,
           resp_req_in, pending_auth_request, pending_count, ch_msg_ready, req_overflow
  );

  // Responder side.
  modport slave (
    input  load_valid, load_msg, msg_pop, auth_msg_ready, auth_msg_out,
           resp_req_out, resp_rearm, req_push, req_slot, pending_auth_request_erase,
    output load_ready, auth_msg_in, msg_avail, last_msg_out, Ack_in_driver,
           resp_req_in, pending_auth_request, pending_count, ch_msg_ready, req_overflow
  );
endinterface

// File: rtl/usb_auth_host_responder.sv
// Host-side responder for the USB Type-C authentication controller: message
// FIFO, delayed acknowledge of controller messages, response request, request queues.
module usb_auth_host_responder #(
  parameter int MSG_LEN = 2048,
  parameter int DEPTH   = 4,
  parameter int NUM_CH  = 2,
  parameter int ACK_LAT = 1
) (
  input logic                    clk,
  input logic                    reset,
  usb_auth_host_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  // ---------------------------------------------------------------------------
  // Message FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------
  logic [MSG_LEN-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        fifo_cnt;
  logic               fifo_full, fifo_empty, do_push, do_pop;

  assign fifo_full  = (fifo_cnt == (AW+1)'(DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign do_push    = bus.load_valid & ~fifo_full;
  assign do_pop     = bus.msg_pop & ~fifo_empty;

  // NOTE: the storage array has no reset; only pointers and count define
  // validity, so clearing the data would just cost a reset tree on every bit.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= bus.load_msg;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign bus.load_ready  = ~fifo_full;
  assign bus.msg_avail   = ~fifo_empty;
  assign bus.auth_msg_in = fifo_empty ? '0 : mem[rd_ptr];

  // ---------------------------------------------------------------------------
  // Delayed acknowledge of controller output messages
  // ---------------------------------------------------------------------------
  typedef enum logic {ACK_IDLE, ACK_WAIT} ack_state_t;

  ack_state_t         ack_state, ack_state_nxt;
  logic [3:0]         ack_cnt, ack_cnt_nxt;
  logic               ack_nxt, ack_q, ready_q, ready_rise, capture;
  logic [MSG_LEN-1:0] last_msg_q;

  assign ready_rise = bus.auth_msg_ready & ~ready_q;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    ack_state_nxt = ack_state;
    ack_cnt_nxt   = ack_cnt;
    ack_nxt       = 1'b0;
    capture       = 1'b0;
    case (ack_state)
      ACK_IDLE: begin
        if (ready_rise) begin
          capture       = 1'b1;
          ack_cnt_nxt   = 4'(ACK_LAT);
          ack_state_nxt = ACK_WAIT;
        end
      end
      ACK_WAIT: begin
        // Rising edges seen here are deliberately dropped.
        if (ack_cnt == 4'd1) begin
          ack_nxt       = 1'b1;
          ack_cnt_nxt   = 4'd0;
          ack_state_nxt = ACK_IDLE;
        end else begin
          ack_cnt_nxt = ack_cnt - 4'd1;
        end
      end
      default: ack_state_nxt = ACK_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_state  <= ACK_IDLE;
      ack_cnt    <= '0;
      ack_q      <= 1'b0;
      ready_q    <= 1'b0;
      last_msg_q <= '0;
    end else begin
      ack_state <= ack_state_nxt;
      ack_cnt   <= ack_cnt_nxt;
      ack_q     <= ack_nxt;
      ready_q   <= bus.auth_msg_ready;
      if (capture) last_msg_q <= bus.auth_msg_out;
    end
  end

  assign bus.Ack_in_driver = ack_q;
  assign bus.last_msg_out  = last_msg_q;

  // ---------------------------------------------------------------------------
  // Response request: clear has priority over re-arm
  // ---------------------------------------------------------------------------
  logic resp_req_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 resp_req_q <= 1'b1;
    else if (bus.resp_req_out) resp_req_q <= 1'b0;
    else if (bus.resp_rearm)   resp_req_q <= 1'b1;
  end

  assign bus.resp_req_in = resp_req_q;

  // ---------------------------------------------------------------------------
  // Per-channel pending request queues (4 x 2-bit, oldest in bits [1:0])
  // ---------------------------------------------------------------------------
  logic [7:0] q_r   [NUM_CH];
  logic [7:0] q_nxt [NUM_CH];
  logic [2:0] n_r   [NUM_CH];
  logic [2:0] n_nxt [NUM_CH];
  logic [NUM_CH-1:0] ovf_r, ovf_set;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      q_nxt[c]   = q_r[c];
      n_nxt[c]   = n_r[c];
      ovf_set[c] = 1'b0;
      if (bus.pending_auth_request_erase[c] && (n_r[c] != 3'd0)) begin
        q_nxt[c] = {2'b00, q_r[c][7:2]};
        if (bus.req_push[c]) q_nxt[c][2*(n_r[c]-3'd1) +: 2] = bus.req_slot[2*c +: 2];
        else                 n_nxt[c] = n_r[c] - 3'd1;
      end else if (bus.req_push[c]) begin
        if (n_r[c] == 3'd4) begin
          ovf_set[c] = 1'b1;
        end else begin
          q_nxt[c][2*n_r[c] +: 2] = bus.req_slot[2*c +: 2];
          n_nxt[c]                = n_r[c] + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        q_r[c] <= '0;
        n_r[c] <= '0;
      end
      ovf_r <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        q_r[c] <= q_nxt[c];
        n_r[c] <= n_nxt[c];
      end
      ovf_r <= ovf_r | ovf_set;
    end
  end

  logic [8*NUM_CH-1:0] pend_flat;
  logic [3*NUM_CH-1:0] cnt_flat;
  logic [NUM_CH-1:0]   ch_rdy;

  always_comb begin
    pend_flat = '0;
    cnt_flat  = '0;
    ch_rdy    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      pend_flat[8*c +: 8] = q_r[c];
      cnt_flat[3*c +: 3]  = n_r[c];
      ch_rdy[c]           = (n_r[c] != 3'd0);
    end
  end

  assign bus.pending_auth_request = pend_flat;
  assign bus.pending_count        = cnt_flat;
  assign bus.ch_msg_ready         = ch_rdy;
  assign bus.req_overflow         = ovf_r;

endmodule

// File: tb/tb_usb_auth_host_responder.sv
// Directed self-checking bench for usb_auth_host_responder (MSG_LEN=64,
// DEPTH=4, NUM_CH=2, ACK_LAT=3).
module tb_usb_auth_host_responder;

  localparam int MSG_LEN = 64;
  localparam int DEPTH   = 4;
  localparam int NUM_CH  = 2;
  localparam int ACK_LAT = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  usb_auth_host_responder_if #(.MSG_LEN(MSG_LEN), .NUM_CH(NUM_CH)) bus ();

  usb_auth_host_responder #(
    .MSG_LEN(MSG_LEN), .DEPTH(DEPTH), .NUM_CH(NUM_CH), .ACK_LAT(ACK_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [MSG_LEN-1:0] vec [5] = '{64'hAAAA_0000_0000_0001, 64'hBBBB_0000_0000_0002,
                                  64'hCCCC_0000_0000_0003, 64'hDDDD_0000_0000_0004,
                                  64'hEEEE_0000_0000_0005};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    n_checks++; if (bus.load_ready !== 1'b1) $display("FAIL reset_load_ready got %b want 1", bus.load_ready); else n_pass++;
    n_checks++; if (bus.resp_req_in !== 1'b1) $display("FAIL reset_resp_req_in got %b want 1", bus.resp_req_in); else n_pass++;
    n_checks++; if (bus.msg_avail !== 1'b0 || bus.auth_msg_in !== '0) $display("FAIL reset_fifo got avail=%b head=%h want 0/0", bus.msg_avail, bus.auth_msg_in); else n_pass++;
    n_checks++; if (bus.Ack_in_driver !== 1'b0 || bus.last_msg_out !== '0) $display("FAIL reset_ack got ack=%b last=%h want 0/0", bus.Ack_in_driver, bus.last_msg_out); else n_pass++;
    n_checks++; if (bus.pending_auth_request !== 16'h0 || bus.pending_count !== 6'h0 || bus.ch_msg_ready !== 2'b00 || bus.req_overflow !== 2'b00)
      $display("FAIL reset_queues got pend=%h cnt=%h rdy=%b ovf=%b want all 0", bus.pending_auth_request, bus.pending_count, bus.ch_msg_ready, bus.req_overflow); else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fifo_fill_drain();
    bus.load_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.load_msg = vec[i];
      tick();
    end
    n_checks++; if (bus.load_ready !== 1'b0) $display("FAIL fill_load_ready got %b want 0", bus.load_ready); else n_pass++;
    n_checks++; if (bus.auth_msg_in !== vec[0]) $display("FAIL fill_head got %h want %h", bus.auth_msg_in, vec[0]); else n_pass++;
    bus.load_msg = vec[4];
    tick();
    n_checks++; if (bus.load_ready !== 1'b0 || bus.auth_msg_in !== vec[0]) $display("FAIL fifth_refused got ready=%b head=%h want 0/%h", bus.load_ready, bus.auth_msg_in, vec[0]); else n_pass++;
    bus.load_valid = 1'b0;
    bus.msg_pop    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus.auth_msg_in !== vec[i] || bus.msg_avail !== 1'b1) $display("FAIL drain_head%0d got %h avail=%b want %h", i, bus.auth_msg_in, bus.msg_avail, vec[i]); else n_pass++;
      tick();
    end
    bus.msg_pop = 1'b0;
    n_checks++; if (bus.msg_avail !== 1'b0 || bus.auth_msg_in !== '0 || bus.load_ready !== 1'b1)
      $display("FAIL drain_empty got avail=%b head=%h ready=%b want 0/0/1", bus.msg_avail, bus.auth_msg_in, bus.load_ready); else n_pass++;
  endtask

  task automatic test_fifo_push_pop();
    bus.load_valid = 1'b1;
    bus.load_msg   = vec[0]; tick();
    bus.load_msg   = vec[1]; tick();
    bus.load_msg   = vec[2];
    bus.msg_pop    = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    n_checks++; if (bus.auth_msg_in !== vec[1] || bus.load_ready !== 1'b1) $display("FAIL pushpop_head got %h ready=%b want %h/1", bus.auth_msg_in, bus.load_ready, vec[1]); else n_pass++;
    tick();
    n_checks++; if (bus.auth_msg_in !== vec[2] || bus.msg_avail !== 1'b1) $display("FAIL pushpop_second got %h avail=%b want %h/1", bus.auth_msg_in, bus.msg_avail, vec[2]); else n_pass++;
    tick();
    bus.msg_pop = 1'b0;
    n_checks++; if (bus.msg_avail !== 1'b0) $display("FAIL pushpop_empty got avail=%b want 0", bus.msg_avail); else n_pass++;
  endtask

  task automatic test_ack_steady();
    int pulses = 0;
    int pulse_k = -1;
    bus.auth_msg_ready = 1'b0;
    tick();
    bus.auth_msg_ready = 1'b1;
    bus.auth_msg_out   = 64'h1234_5678_9ABC_DEF0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) begin
        n_checks++; if (bus.last_msg_out !== 64'h1234_5678_9ABC_DEF0) $display("FAIL ack_capture got %h want 123456789abcdef0", bus.last_msg_out); else n_pass++;
        bus.auth_msg_out = 64'hFFFF_0000_FFFF_0000;
      end
      if (bus.Ack_in_driver === 1'b1) begin
        pulses++;
        pulse_k = k;
      end
    end
    n_checks++; if (pulses != 1 || pulse_k != 1 + ACK_LAT) $display("FAIL ack_single_pulse got pulses=%0d at=%0d want 1 at %0d", pulses, pulse_k, 1 + ACK_LAT); else n_pass++;
    n_checks++; if (bus.last_msg_out !== 64'h1234_5678_9ABC_DEF0) $display("FAIL ack_hold_value got %h want 123456789abcdef0", bus.last_msg_out); else n_pass++;
    bus.auth_msg_ready = 1'b0;
    tick();
  endtask

  task automatic test_ack_ignore();
    int pulses = 0;
    int pulse_k = -1;
    bus.auth_msg_ready = 1'b1;
    bus.auth_msg_out   = 64'h0000_0000_0000_1111;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 1) begin
        bus.auth_msg_ready = 1'b0;
        bus.auth_msg_out   = 64'h0000_0000_0000_2222;
      end else if (k == 2) begin
        bus.auth_msg_ready = 1'b1;
      end
      if (bus.Ack_in_driver === 1'b1) begin
        pulses++;
        pulse_k = k;
      end
    end
    n_checks++; if (pulses != 1 || pulse_k != 1 + ACK_LAT) $display("FAIL ack_ignore_pulse got pulses=%0d at=%0d want 1 at %0d", pulses, pulse_k, 1 + ACK_LAT); else n_pass++;
    n_checks++; if (bus.last_msg_out !== 64'h0000_0000_0000_1111) $display("FAIL ack_ignore_capture got %h want 1111", bus.last_msg_out); else n_pass++;
    bus.auth_msg_ready = 1'b0;
    tick();
  endtask

  task automatic test_queue_overflow();
    logic [1:0] slots [4] = '{2'd2, 2'd1, 2'd3, 2'd2};
    bus.req_push = 2'b10;
    for (int i = 0; i < 4; i++) begin
      bus.req_slot = {slots[i], 2'b00};
      tick();
    end
    n_checks++; if (bus.pending_auth_request[15:8] !== 8'b10_11_01_10 || bus.pending_count[5:3] !== 3'd4)
      $display("FAIL q1_full got %b cnt=%0d want 10110110 cnt=4", bus.pending_auth_request[15:8], bus.pending_count[5:3]); else n_pass++;
    n_checks++; if (bus.ch_msg_ready !== 2'b10 || bus.req_overflow !== 2'b00) $display("FAIL q1_flags got rdy=%b ovf=%b want 10/00", bus.ch_msg_ready, bus.req_overflow); else n_pass++;
    bus.req_slot = 4'b01_00;
    tick();
    bus.req_push = 2'b00;
    n_checks++; if (bus.req_overflow !== 2'b10 || bus.pending_auth_request[15:8] !== 8'b10_11_01_10 || bus.pending_count[5:3] !== 3'd4)
      $display("FAIL q1_overflow got ovf=%b q=%b cnt=%0d want 10/10110110/4", bus.req_overflow, bus.pending_auth_request[15:8], bus.pending_count[5:3]); else n_pass++;
    bus.pending_auth_request_erase = 2'b10;
    tick();
    bus.pending_auth_request_erase = 2'b00;
    n_checks++; if (bus.pending_auth_request[15:8] !== 8'b00_10_11_01 || bus.pending_count[5:3] !== 3'd3 || bus.req_overflow !== 2'b10)
      $display("FAIL q1_erase got q=%b cnt=%0d ovf=%b want 00101101/3/10", bus.pending_auth_request[15:8], bus.pending_count[5:3], bus.req_overflow); else n_pass++;
  endtask

  task automatic test_queue_push_erase();
    bus.req_push = 2'b01;
    bus.req_slot = 4'b00_10; tick();
    bus.req_slot = 4'b00_01; tick();
    n_checks++; if (bus.pending_auth_request[7:0] !== 8'b0000_01_10 || bus.pending_count[2:0] !== 3'd2)
      $display("FAIL q0_fill got %b cnt=%0d want 00000110/2", bus.pending_auth_request[7:0], bus.pending_count[2:0]); else n_pass++;
    bus.req_slot = 4'b00_11;
    bus.pending_auth_request_erase = 2'b01;
    tick();
    bus.req_push = 2'b00;
    n_checks++; if (bus.pending_auth_request[7:0] !== 8'b0000_11_01 || bus.pending_count[2:0] !== 3'd2)
      $display("FAIL q0_push_erase got %b cnt=%0d want 00001101/2", bus.pending_auth_request[7:0], bus.pending_count[2:0]); else n_pass++;
    n_checks++; if (bus.pending_auth_request[15:8] !== 8'b00_10_11_01 || bus.pending_count[5:3] !== 3'd3 || bus.req_overflow !== 2'b10)
      $display("FAIL q1_unaffected got q=%b cnt=%0d ovf=%b want 00101101/3/10", bus.pending_auth_request[15:8], bus.pending_count[5:3], bus.req_overflow); else n_pass++;
    tick(); tick(); tick();
    bus.pending_auth_request_erase = 2'b00;
    n_checks++; if (bus.pending_auth_request[7:0] !== 8'h00 || bus.pending_count[2:0] !== 3'd0 || bus.ch_msg_ready[0] !== 1'b0)
      $display("FAIL q0_erase_empty got q=%b cnt=%0d rdy=%b want 0/0/0", bus.pending_auth_request[7:0], bus.pending_count[2:0], bus.ch_msg_ready[0]); else n_pass++;
  endtask

  task automatic test_resp_req();
    bus.resp_req_out = 1'b1; tick(); bus.resp_req_out = 1'b0;
    n_checks++; if (bus.resp_req_in !== 1'b0) $display("FAIL resp_clear got %b want 0", bus.resp_req_in); else n_pass++;
    bus.resp_rearm = 1'b1; tick(); bus.resp_rearm = 1'b0;
    n_checks++; if (bus.resp_req_in !== 1'b1) $display("FAIL resp_rearm got %b want 1", bus.resp_req_in); else n_pass++;
    bus.resp_req_out = 1'b1; bus.resp_rearm = 1'b1; tick();
    bus.resp_req_out = 1'b0; bus.resp_rearm = 1'b0;
    n_checks++; if (bus.resp_req_in !== 1'b0) $display("FAIL resp_both got %b want 0", bus.resp_req_in); else n_pass++;
  endtask

  task automatic test_reset_mid_ack();
    int pulses = 0;
    bus.load_valid = 1'b1; bus.load_msg = vec[3]; tick(); bus.load_valid = 1'b0;
    bus.auth_msg_ready = 1'b1;
    bus.auth_msg_out   = 64'h5555_5555_5555_5555;
    tick();
    tick();
    reset = 1'b1;
    bus.auth_msg_ready = 1'b0;
    #1;
    n_checks++; if (bus.resp_req_in !== 1'b1 || bus.msg_avail !== 1'b0 || bus.last_msg_out !== '0)
      $display("FAIL midreset_state got resp=%b avail=%b last=%h want 1/0/0", bus.resp_req_in, bus.msg_avail, bus.last_msg_out); else n_pass++;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (bus.Ack_in_driver === 1'b1) pulses++;
      tick();
    end
    n_checks++; if (pulses != 0) $display("FAIL midreset_no_pulse got %0d pulses want 0", pulses); else n_pass++;
  endtask

  initial begin
    bus.load_valid = 1'b0;
    bus.load_msg = '0;
    bus.msg_pop = 1'b0;
    bus.auth_msg_ready = 1'b0;
    bus.auth_msg_out = '0;
    bus.resp_req_out = 1'b0;
    bus.resp_rearm = 1'b0;
    bus.req_push = '0;
    bus.req_slot = '0;
    bus.pending_auth_request_erase = '0;

    test_reset();
    test_fifo_fill_drain();
    test_fifo_push_pop();
    test_ack_steady();
    test_ack_ignore();
    test_queue_overflow();
    test_queue_push_erase();
    test_resp_req();
    test_reset_mid_ack();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
